// File: rtl/bypass_scoreboard.sv
// Forwarding/hazard scoreboard for the in-order pipeline: tracks in-flight destinations
// per post-decode stage, resolves per-source bypass and raises load-use stalls.
module bypass_scoreboard #(
  parameter int ARCH_LEN     = 32,
  parameter int REG_FILE_LEN = 32,
  parameter int NUM_STAGES   = 3,
  parameter int FLUSH_STAGES = 1,
  parameter int CNT_W        = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             advance_i,
  input  logic                             flush_i,
  input  logic                             issue_valid_i,
  input  logic [$clog2(REG_FILE_LEN)-1:0]  issue_dst_i,
  input  logic                             issue_we_i,
  input  logic [$clog2(NUM_STAGES)-1:0]    issue_rdy_stage_i,
  input  logic [$clog2(REG_FILE_LEN)-1:0]  src1_i,
  input  logic [$clog2(REG_FILE_LEN)-1:0]  src2_i,
  input  logic                             use_src1_i,
  input  logic                             use_src2_i,
  input  logic [ARCH_LEN-1:0]              rf_data1_i,
  input  logic [ARCH_LEN-1:0]              rf_data2_i,
  input  logic [NUM_STAGES*ARCH_LEN-1:0]   stage_data_i,
  output logic                             dep_src1_o,
  output logic                             dep_src2_o,
  output logic [$clog2(NUM_STAGES)-1:0]    byp_sel1_o,
  output logic [$clog2(NUM_STAGES)-1:0]    byp_sel2_o,
  output logic [ARCH_LEN-1:0]              op_data1_o,
  output logic [ARCH_LEN-1:0]              op_data2_o,
  output logic                             stall_o,
  output logic [CNT_W-1:0]                 stall_cnt_o
);

  localparam int REG_W = $clog2(REG_FILE_LEN);
  localparam int SEL_W = $clog2(NUM_STAGES);

  logic [NUM_STAGES-1:0] valid_r;
  logic [REG_W-1:0]      dst_r [NUM_STAGES];
  logic [SEL_W-1:0]      rdy_r [NUM_STAGES];
  logic [CNT_W-1:0]      stall_cnt_r;

  logic [NUM_STAGES-1:0] valid_nxt_s;
  logic [REG_W-1:0]      dst_nxt_s [NUM_STAGES];
  logic [SEL_W-1:0]      rdy_nxt_s [NUM_STAGES];
  logic [SEL_W-1:0]      rdy_clamp_s;

  logic [ARCH_LEN-1:0]   stage_s [NUM_STAGES];
  logic [REG_W-1:0]      src_s [2];
  logic [1:0]            use_s;
  logic [ARCH_LEN-1:0]   rf_s [2];
  logic [NUM_STAGES-1:0] hit_s [2];
  logic [SEL_W-1:0]      sel_s [2];
  logic [ARCH_LEN-1:0]   op_s [2];
  logic [1:0]            dep_s;
  logic [1:0]            ready_s;
  logic [1:0]            wait_s;
  logic                  stall_s;

  // Gather per-source inputs into arrays and split the stage result bus.
  always_comb begin
    src_s[0] = src1_i;
    src_s[1] = src2_i;
    use_s    = {use_src2_i, use_src1_i};
    rf_s[0]  = rf_data1_i;
    rf_s[1]  = rf_data2_i;
    for (int k = 0; k < NUM_STAGES; k++) begin
      stage_s[k] = stage_data_i[k*ARCH_LEN +: ARCH_LEN];
    end
  end

  // Per-source match vector against every tracked entry; x0 never matches.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        hit_s[n][k] = valid_r[k] && (dst_r[k] == src_s[n]) && (src_s[n] != '0) && use_s[n];
      end
    end
  end

  // Youngest match wins: scanning oldest to youngest lets the lowest index overwrite.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      sel_s[n] = '0;
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        sel_s[n] = hit_s[n][k] ? SEL_W'(k) : sel_s[n];
      end
      dep_s[n]   = |hit_s[n];
      ready_s[n] = (sel_s[n] >= rdy_r[sel_s[n]]);
      op_s[n]    = (dep_s[n] && ready_s[n]) ? stage_s[sel_s[n]] : rf_s[n];
      wait_s[n]  = dep_s[n] && !ready_s[n];
    end
    stall_s = issue_valid_i && (|wait_s);
  end

  // Clamp the producer's ready stage into the tracked window.
  always_comb begin
    if (32'(issue_rdy_stage_i) >= NUM_STAGES) begin
      rdy_clamp_s = SEL_W'(NUM_STAGES - 1);
    end else begin
      rdy_clamp_s = issue_rdy_stage_i;
    end
  end

  // Next entry state: shift on advance, then flush kills the youngest entries.
  always_comb begin
    valid_nxt_s = valid_r;
    dst_nxt_s   = dst_r;
    rdy_nxt_s   = rdy_r;
    if (advance_i) begin
      for (int k = 1; k < NUM_STAGES; k++) begin
        valid_nxt_s[k] = valid_r[k-1];
        dst_nxt_s[k]   = dst_r[k-1];
        rdy_nxt_s[k]   = rdy_r[k-1];
      end
      valid_nxt_s[0] = issue_valid_i && issue_we_i && !stall_s;
      dst_nxt_s[0]   = issue_dst_i;
      rdy_nxt_s[0]   = rdy_clamp_s;
    end else begin
      valid_nxt_s = valid_r;
    end
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (flush_i && (k < FLUSH_STAGES)) begin
        valid_nxt_s[k] = 1'b0;
      end else begin
        valid_nxt_s[k] = valid_nxt_s[k];
      end
    end
  end

  // Entry state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        dst_r[k] <= '0;
        rdy_r[k] <= '0;
      end
    end else begin
      valid_r <= valid_nxt_s;
      dst_r   <= dst_nxt_s;
      rdy_r   <= rdy_nxt_s;
    end
  end

  // Saturating stall statistics, counted whether or not the pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= '0;
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign dep_src1_o  = dep_s[0];
  assign dep_src2_o  = dep_s[1];
  assign byp_sel1_o  = sel_s[0];
  assign byp_sel2_o  = sel_s[1];
  assign op_data1_o  = op_s[0];
  assign op_data2_o  = op_s[1];
  assign stall_o     = stall_s;
  assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Self-checking bench for bypass_scoreboard: a reference model predicts outputs into a
// queue each cycle, directed scenarios add fixed expectations, then a random phase.
module tb_bypass_scoreboard;

  localparam int AL = 32;
  localparam int NS = 3;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          advance, flush, issue_valid, issue_we, use1, use2;
  logic [4:0]    issue_dst, src1, src2;
  logic [1:0]    issue_rdy;
  logic [31:0]   rf1, rf2;
  logic [31:0]   sd [NS];
  logic [NS*AL-1:0] stage_data;
  logic          dep1, dep2, stall;
  logic [1:0]    sel1, sel2;
  logic [31:0]   op1, op2;
  logic [CW-1:0] stall_cnt;

  assign stage_data = {sd[2], sd[1], sd[0]};

  bypass_scoreboard #(.ARCH_LEN(AL), .REG_FILE_LEN(32), .NUM_STAGES(NS),
                      .FLUSH_STAGES(1), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .advance_i(advance), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_dst_i(issue_dst), .issue_we_i(issue_we),
    .issue_rdy_stage_i(issue_rdy), .src1_i(src1), .src2_i(src2),
    .use_src1_i(use1), .use_src2_i(use2), .rf_data1_i(rf1), .rf_data2_i(rf2),
    .stage_data_i(stage_data), .dep_src1_o(dep1), .dep_src2_o(dep2),
    .byp_sel1_o(sel1), .byp_sel2_o(sel2), .op_data1_o(op1), .op_data2_o(op2),
    .stall_o(stall), .stall_cnt_o(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dep1, dep2, stall;
    logic [1:0]  sel1, sel2;
    logic [31:0] op1, op2;
    int          cnt;
  } exp_t;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model state
  logic       m_v [NS];
  logic [4:0] m_d [NS];
  int         m_r [NS];
  int         m_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NS; k++) begin
      m_v[k] = 1'b0; m_d[k] = 5'd0; m_r[k] = 0;
    end
    m_cnt = 0;
  endtask

  function automatic void resolve(input logic [4:0] src, input logic use_, input logic [31:0] rf,
                                  output logic dep, output logic [1:0] sel,
                                  output logic [31:0] op, output logic st);
    dep = 1'b0; sel = 2'd0; op = rf; st = 1'b0;
    if (use_ && src != 5'd0) begin
      for (int k = 0; k < NS; k++) begin
        if (m_v[k] && m_d[k] == src) begin
          dep = 1'b1;
          sel = 2'(k);
          if (k >= m_r[k]) op = sd[k];
          else st = 1'b1;
          break;
        end
      end
    end
  endfunction

  function automatic exp_t predict();
    exp_t e;
    logic s1, s2;
    resolve(src1, use1, rf1, e.dep1, e.sel1, e.op1, s1);
    resolve(src2, use2, rf2, e.dep2, e.sel2, e.op2, s2);
    e.stall = issue_valid && (s1 || s2);
    e.cnt   = m_cnt;
    return e;
  endfunction

  // Sample mid-cycle: push the prediction, pop it and compare with the DUT.
  task automatic check_cycle();
    exp_t e;
    #3;
    exp_q.push_back(predict());
    e = exp_q.pop_front();
    check_val("dep1", 32'(dep1), 32'(e.dep1));
    check_val("dep2", 32'(dep2), 32'(e.dep2));
    check_val("sel1", 32'(sel1), 32'(e.sel1));
    check_val("sel2", 32'(sel2), 32'(e.sel2));
    check_val("op1", op1, e.op1);
    check_val("op2", op2, e.op2);
    check_val("stall", 32'(stall), 32'(e.stall));
    check_val("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
  endtask

  // Clock edge: advance the model with the inputs the DUT saw.
  task automatic commit();
    exp_t e;
    e = predict();
    @(posedge clk);
    if (rst_n) begin
      if (e.stall && m_cnt < (1 << CW) - 1) m_cnt++;
      if (advance) begin
        for (int k = NS - 1; k > 0; k--) begin
          m_v[k] = m_v[k-1]; m_d[k] = m_d[k-1]; m_r[k] = m_r[k-1];
        end
        m_v[0] = issue_valid && issue_we && !e.stall;
        m_d[0] = issue_dst;
        m_r[0] = (int'(issue_rdy) > NS - 1) ? NS - 1 : int'(issue_rdy);
      end
      if (flush) m_v[0] = 1'b0;
    end
    #1;
  endtask

  task automatic set_issue(input logic v, input logic we, input logic [4:0] d, input logic [1:0] r);
    issue_valid = v; issue_we = we; issue_dst = d; issue_rdy = r;
  endtask

  task automatic set_src(input logic [4:0] a, input logic ua, input logic [4:0] b, input logic ub);
    src1 = a; use1 = ua; src2 = b; use2 = ub;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; advance = 1'b1; flush = 1'b0;
    set_issue(1'b0, 1'b0, 5'd0, 2'd0);
    set_src(5'd5, 1'b1, 5'd5, 1'b1);
    rf1 = 32'h1111_1111; rf2 = 32'h2222_2222;
    sd[0] = 32'hDEAD_BEEF; sd[1] = 32'hCAFE_F00D; sd[2] = 32'h0BAD_C0DE;

    // reset state
    check_cycle();
    check_val("rst_op1", op1, 32'h1111_1111);
    check_val("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_src(5'd0, 1'b0, 5'd0, 1'b0);
    commit();

    // ALU back-to-back
    set_issue(1'b1, 1'b1, 5'd5, 2'd0); check_cycle(); commit();
    set_issue(1'b1, 1'b0, 5'd0, 2'd0); set_src(5'd5, 1'b1, 5'd0, 1'b0);
    check_cycle();
    check_val("alu_dep", 32'(dep1), 32'd1);
    check_val("alu_sel", 32'(sel1), 32'd0);
    check_val("alu_op", op1, 32'hDEAD_BEEF);
    check_val("alu_stall", 32'(stall), 32'd0);
    commit();

    // load-use: one stall, then bypass from stage 1
    set_issue(1'b1, 1'b1, 5'd7, 2'd1); set_src(5'd0, 1'b0, 5'd0, 1'b0);
    check_cycle(); commit();
    set_issue(1'b1, 1'b0, 5'd0, 2'd0); set_src(5'd7, 1'b1, 5'd0, 1'b0);
    check_cycle();
    check_val("lu_stall", 32'(stall), 32'd1);
    commit();
    check_cycle();
    check_val("lu_sel", 32'(sel1), 32'd1);
    check_val("lu_op", op1, 32'hCAFE_F00D);
    check_val("lu_stall2", 32'(stall), 32'd0);
    check_val("lu_cnt", 32'(stall_cnt), 32'd1);
    commit();

    // youngest of two matching producers wins
    set_src(5'd0, 1'b0, 5'd0, 1'b0);
    set_issue(1'b1, 1'b1, 5'd3, 2'd0); check_cycle(); commit();
    set_issue(1'b1, 1'b1, 5'd9, 2'd0); check_cycle(); commit();
    set_issue(1'b1, 1'b1, 5'd3, 2'd0); check_cycle(); commit();
    set_issue(1'b1, 1'b0, 5'd0, 2'd0); set_src(5'd3, 1'b1, 5'd3, 1'b1);
    check_cycle();
    check_val("young_sel", 32'(sel1), 32'd0);
    check_val("young_op", op2, 32'hDEAD_BEEF);
    commit();

    // x0 never matches, unused source never matches
    set_src(5'd0, 1'b0, 5'd0, 1'b0);
    set_issue(1'b1, 1'b1, 5'd4, 2'd0); check_cycle(); commit();
    set_issue(1'b1, 1'b1, 5'd0, 2'd0); check_cycle(); commit();
    set_issue(1'b1, 1'b0, 5'd0, 2'd0); set_src(5'd0, 1'b1, 5'd4, 1'b0);
    check_cycle();
    check_val("x0_dep", 32'(dep1), 32'd0);
    check_val("x0_op", op1, 32'h1111_1111);
    check_val("nouse_dep", 32'(dep2), 32'd0);
    commit();

    // back-pressure with a stalling load-use, then flush
    set_src(5'd0, 1'b0, 5'd0, 1'b0);
    set_issue(1'b1, 1'b1, 5'd11, 2'd0); check_cycle(); commit();
    set_issue(1'b1, 1'b1, 5'd8, 2'd1); check_cycle(); commit();
    set_issue(1'b1, 1'b0, 5'd0, 2'd0); set_src(5'd8, 1'b1, 5'd0, 1'b0);
    advance = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_cycle();
      check_val("bp_stall", 32'(stall), 32'd1);
      commit();
    end
    check_val("bp_cnt", 32'(stall_cnt), 32'd4);
    flush = 1'b1; check_cycle(); commit();
    flush = 1'b0; set_src(5'd11, 1'b1, 5'd8, 1'b1);
    check_cycle();
    check_val("fl_dep1", 32'(dep1), 32'd1);
    check_val("fl_sel1", 32'(sel1), 32'd1);
    check_val("fl_op1", op1, 32'hCAFE_F00D);
    check_val("fl_dep2", 32'(dep2), 32'd0);
    commit();

    // saturation of the stall counter
    advance = 1'b1; set_src(5'd0, 1'b0, 5'd0, 1'b0);
    set_issue(1'b1, 1'b1, 5'd12, 2'd2); check_cycle(); commit();
    advance = 1'b0; set_issue(1'b1, 1'b0, 5'd0, 2'd0); set_src(5'd12, 1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      check_cycle(); commit();
    end
    check_val("sat_cnt", 32'(stall_cnt), 32'd15);

    // asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_val("arst_stall", 32'(stall), 32'd0);
    check_val("arst_dep", 32'(dep1), 32'd0);
    check_val("arst_op", op1, 32'h1111_1111);
    check_val("arst_cnt", 32'(stall_cnt), 32'd0);
    #3 rst_n = 1'b1;
    advance = 1'b1;
    commit();

    // random traffic against the model
    for (int i = 0; i < 200; i++) begin
      advance = ($urandom_range(0, 9) < 8);
      flush   = ($urandom_range(0, 9) == 0);
      set_issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      set_src(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      rf1 = $urandom; rf2 = $urandom;
      sd[0] = $urandom; sd[1] = $urandom; sd[2] = $urandom;
      check_cycle();
      commit();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bypass_scoreboard.md
Name: bypass_scoreboard

Overview:
- Parametrised forwarding/hazard unit for the in-order RISC-V pipeline; the sequential successor of the per-source dependency flag pair.
- Tracks the destination register of every in-flight instruction across NUM_STAGES post-decode stages.
- Each producer carries its data-ready stage: stage 0 for ALU results available at EXE, a later stage for loads and multiplies.
- Per decode source, the block:
  - flags the dependency;
  - selects the youngest ready producer's data for bypass;
  - otherwise raises a stall and inserts a bubble.

Parameters:
ARCH_LEN, 32, data width
REG_FILE_LEN, 32, architectural register count; register 0 is hard-zero
NUM_STAGES, 3, tracked post-decode stages (index 0 = EXE, youngest)
FLUSH_STAGES, 1, youngest entries invalidated by flush_i
CNT_W, 32, stall statistics counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
advance_i  in  1  pipeline moves this cycle (0 = downstream back-pressure)
flush_i  in  1  kill youngest FLUSH_STAGES entries (branch redirect)
issue_valid_i  in  1  decode holds a valid instruction
issue_dst_i  in  $clog2(REG_FILE_LEN)  decode destination register
issue_we_i  in  1  decode instruction writes a register
issue_rdy_stage_i  in  $clog2(NUM_STAGES)  stage index at whose output the result exists
src1_i, src2_i  in  $clog2(REG_FILE_LEN)  decode source registers
use_src1_i, use_src2_i  in  1  source actually read
rf_data1_i, rf_data2_i  in  ARCH_LEN  register-file read data
stage_data_i  in  NUM_STAGES*ARCH_LEN  result bus of each stage, slice k = stage k
dep_src1_o, dep_src2_o  out  1  in-flight producer matches source
byp_sel1_o, byp_sel2_o  out  $clog2(NUM_STAGES)  stage supplying the forwarded value
op_data1_o, op_data2_o  out  ARCH_LEN  resolved operand (forwarded or rf data)
stall_o  out  1  decode must hold; a bubble is inserted
stall_cnt_o  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (async, rst_n=0): all entry valid bits 0 and stall_cnt_o=0. All combinational outputs then resolve to: dep=0, sel=0, op_data=rf_data, stall_o=0.
- Entry k holds {valid, dst, rdy_stage}. issue_rdy_stage_i >= NUM_STAGES is clamped to NUM_STAGES-1 on capture.
- Match for source n at entry k: valid && dst==src_n && src_n!=0 && use_src_n. Entries are stored only when issue_we_i=1.
- Multiple matches: the lowest index (youngest) wins. Older matches are ignored even if ready.
- Outputs are combinational from entry state and inputs (zero latency):
  - dep_src_n_o = any match.
  - If the winner k has k >= rdy_stage: byp_sel_n_o=k, op_data_n_o=stage_data_i[k], no stall.
  - Else: stall contribution 1, byp_sel_n_o=k, op_data_n_o=rf_data.
  - No match: sel=0, op_data=rf_data.
- stall_o = issue_valid_i && (stall contribution of src1 || stall contribution of src2).
- Sequential update on rising clk, only when advance_i=1:
  - entry[k] <= entry[k-1] for k=1..NUM_STAGES-1; the oldest entry retires (its RF write happens that cycle).
  - entry[0] <= issue_valid_i && issue_we_i && !stall_o, stored as {1, issue_dst_i, clamped rdy}; otherwise a bubble (valid=0).
- advance_i=0: all entries hold; outputs are still recomputed each cycle.
- flush_i=1 clears the valid bit of entries 0..FLUSH_STAGES-1 after any shift and overrides the new issue. Flush acts even when advance_i=0.
- stall_cnt_o increments on every cycle with stall_o=1 (regardless of advance_i) and saturates at 2^CNT_W-1.
- issue_dst_i=0 with issue_we_i=1 is stored but never matches.
- Reset asserted mid-operation clears everything immediately; no partial shift completes.

Test Plan:
- ALU back-to-back: issue x5 (rdy 0), advance; next decode reads src1=x5 → dep_src1_o=1, byp_sel1_o=0, op_data1_o=stage_data_i[0]=0xDEADBEEF, stall_o=0.
- Load-use: issue x7 (rdy 1), advance; decode reads x7 → stall_o=1 for one cycle with a bubble inserted. Next cycle: byp_sel1_o=1, op_data1_o=stage_data_i[1], stall_o=0, stall_cnt_o=1.
- Youngest wins: x3 in entry 2 (ready) and x3 in entry 0 (rdy 0); read x3 → byp_sel_o=0, not 2.
- x0 and unused source: entry 0 dst=x0; read src1=x0 → dep=0, op_data=rf_data1_i. Entry dst=x4 with use_src2_i=0 and src2=x4 → dep_src2_o=0.
- Back-pressure and flush: hold advance_i=0 for 3 cycles with a stalling load-use → entries unchanged, stall_cnt_o +3. Then flush_i=1 → entry 0 invalid, the producer in entry 1 is retained.
- Saturation and reset: CNT_W=4, stall 20 cycles → stall_cnt_o=15. Drop rst_n mid-cycle → all outputs return to reset values asynchronously.
